// File: rtl/handshake_receiver_pkg.sv
// Shared types and parameter checks for the four-phase handshake receiver.
package hs_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    STALL = 2'd1,
    ACK   = 2'd2
  } hs_state_t;

  localparam int HS_MIN_SYNC = 2;

  // Legal when the synchronizer is deep enough and the FIFO depth is a power of two >= 2.
  function automatic bit hs_params_ok(input int sync_stages, input int depth);
    return (sync_stages >= HS_MIN_SYNC) && (depth >= 2) && ((depth & (depth - 1)) == 0);
  endfunction

endpackage

// File: rtl/handshake_receiver_if.sv
// Handshake source side plus downstream valid/ready stream of the receiver.
interface handshake_receiver_if #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4
);

  logic                     req_ready;
  logic [DATA_W-1:0]        req_data;
  logic                     req_ack;
  logic                     out_valid;
  logic [DATA_W-1:0]        out_data;
  logic                     out_ready;
  logic [$clog2(DEPTH):0]   fifo_count;

  modport slave (
    input  req_ready, req_data, out_ready,
    output req_ack, out_valid, out_data, fifo_count
  );

  modport master (
    output req_ready, req_data, out_ready,
    input  req_ack, out_valid, out_data, fifo_count
  );

endinterface

// File: rtl/handshake_receiver_fifo.sv
// Synchronous show-ahead FIFO; head word is visible on pop_data while not empty.
module hs_fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [DATA_W-1:0]        push_data,
  input  logic                     pop,
  output logic [DATA_W-1:0]        pop_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr_reg;
  logic [AW-1:0]     rd_ptr_reg;
  logic [AW:0]       count_reg;
  logic              do_push;
  logic              do_pop;

  assign full    = (count_reg == FULL_CNT);
  assign empty   = (count_reg == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign count   = count_reg;
  // Empty FIFO presents zero rather than stale storage.
  assign pop_data = empty ? '0 : mem[rd_ptr_reg];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr_reg] <= push_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      end
      if (do_pop) begin
        rd_ptr_reg <= rd_ptr_reg + 1'b1;
      end
      if (do_push && !do_pop) begin
        count_reg <= count_reg + 1'b1;
      end else if (do_pop && !do_push) begin
        count_reg <= count_reg - 1'b1;
      end
    end
  end

endmodule

// File: rtl/handshake_receiver.sv
// Destination end of the four-phase req_ready/req_ack handshake, buffering
// captured words into a show-ahead FIFO presented on a valid/ready stream.
module handshake_receiver
  import hs_pkg::*;
#(
  parameter int DATA_W      = 8,
  parameter int SYNC_STAGES = 2,
  parameter int DEPTH       = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  handshake_receiver_if.slave  bus
);

  localparam logic [1:0] S_IDLE  = IDLE;
  localparam logic [1:0] S_STALL = STALL;
  localparam logic [1:0] S_ACK   = ACK;

  if (!hs_params_ok(SYNC_STAGES, DEPTH)) begin : g_bad_params
    $error("handshake_receiver: SYNC_STAGES must be >= 2 and DEPTH a power of two >= 2");
  end

  logic [SYNC_STAGES-1:0]  sync_reg;
  logic                    ready_s;
  logic [1:0]              state_reg;
  logic [1:0]              state_next;
  logic                    ack_reg;
  logic                    ack_next;
  logic                    push_en;
  logic                    fifo_full;
  logic                    fifo_empty;
  logic [DATA_W-1:0]       fifo_data;
  logic [$clog2(DEPTH):0]  fifo_count;

  assign ready_s = sync_reg[SYNC_STAGES-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_reg <= '0;
    end else begin
      sync_reg <= {sync_reg[SYNC_STAGES-2:0], bus.req_ready};
    end
  end

  // Full is the pre-edge occupancy, so a same-cycle pop never admits a push.
  always_comb begin
    state_next = state_reg;
    ack_next   = ack_reg;
    push_en    = 1'b0;
    case (state_reg)
      S_IDLE: begin
        if (ready_s) begin
          if (!fifo_full) begin
            push_en    = 1'b1;
            ack_next   = 1'b1;
            state_next = S_ACK;
          end else begin
            state_next = S_STALL;
          end
        end
      end
      S_STALL: begin
        if (!fifo_full) begin
          push_en    = 1'b1;
          ack_next   = 1'b1;
          state_next = S_ACK;
        end
      end
      S_ACK: begin
        if (!ready_s) begin
          ack_next   = 1'b0;
          state_next = S_IDLE;
        end
      end
      default: begin
        ack_next   = 1'b0;
        state_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= S_IDLE;
      ack_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      ack_reg   <= ack_next;
    end
  end

  hs_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push_en),
    .push_data (bus.req_data),
    .pop       (bus.out_ready),
    .pop_data  (fifo_data),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  assign bus.req_ack    = ack_reg;
  assign bus.out_valid  = !fifo_empty;
  assign bus.out_data   = fifo_data;
  assign bus.fifo_count = fifo_count;

endmodule

// File: tb/tb_handshake_receiver.sv
// Self-checking bench for handshake_receiver: vector table, corner sequences, scoreboard.
module tb_handshake_receiver;

  localparam int DATA_W = 8;
  localparam int DEPTH  = 4;

  typedef struct {
    logic [7:0] data;
    logic [2:0] exp_count;
  } vec_t;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;
  logic [7:0] exp_q[$];
  bit   rand_done;

  handshake_receiver_if #(.DATA_W(DATA_W), .DEPTH(DEPTH)) bus ();

  handshake_receiver #(
    .DATA_W      (DATA_W),
    .SYNC_STAGES (2),
    .DEPTH       (DEPTH)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_ack(input logic v, input string name);
    int n;
    n = 0;
    while (bus.req_ack !== v && n < 200) begin
      tick();
      n++;
    end
    check(name, 32'(bus.req_ack), 32'(v));
  endtask

  task automatic handshake(input logic [7:0] d);
    bus.req_data  = d;
    bus.req_ready = 1'b1;
    exp_q.push_back(d);
    wait_ack(1'b1, "ack_rise");
    bus.req_ready = 1'b0;
    wait_ack(1'b0, "ack_fall");
  endtask

  task automatic drain();
    int n;
    n = 0;
    bus.out_ready = 1'b1;
    while (bus.fifo_count != 0 && n < 100) begin
      tick();
      n++;
    end
    bus.out_ready = 1'b0;
    check("drain_count", 32'(bus.fifo_count), 32'd0);
    check("sb_empty", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    vec_t vecs[4];
    logic [7:0] e;
    checks    = 0;
    failures  = 0;
    rand_done = 1'b0;
    rst_n         = 1'b0;
    bus.req_ready = 1'b0;
    bus.req_data  = '0;
    bus.out_ready = 1'b0;

    // Scoreboard monitor and ack invariant, sampled on the falling edge.
    fork
      forever begin
        @(negedge clk);
        if (rst_n && bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
          if (exp_q.size() == 0) begin
            check("sb_unexpected_pop", 32'(bus.out_data), 32'hFFFF_FFFF);
          end else begin
            e = exp_q.pop_front();
            $display("pop data=%02h expected=%02h", bus.out_data, e);
            check("sb_data", 32'(bus.out_data), 32'(e));
          end
        end
        if (dut.state_reg != 2'd2) begin
          check("ack_outside_ack", 32'(bus.req_ack), 32'd0);
        end
      end
    join_none

    tick(2);
    check("rst_ack", 32'(bus.req_ack), 32'd0);
    check("rst_valid", 32'(bus.out_valid), 32'd0);
    check("rst_data", 32'(bus.out_data), 32'd0);
    check("rst_count", 32'(bus.fifo_count), 32'd0);
    rst_n = 1'b1;
    tick(2);

    // Single transfer with exact edge timing.
    bus.out_ready = 1'b1;
    bus.req_data  = 8'h05;
    bus.req_ready = 1'b1;
    exp_q.push_back(8'h05);
    tick(); check("e0_ack", 32'(bus.req_ack), 32'd0);
    tick(); check("e1_ack", 32'(bus.req_ack), 32'd0);
    tick();
    check("e2_ack", 32'(bus.req_ack), 32'd1);
    check("e2_valid", 32'(bus.out_valid), 32'd1);
    check("e2_data", 32'(bus.out_data), 32'h05);
    tick();
    check("e3_valid", 32'(bus.out_valid), 32'd0);
    check("e3_count", 32'(bus.fifo_count), 32'd0);
    tick(9);
    bus.req_ready = 1'b0;
    tick(); check("f0_ack", 32'(bus.req_ack), 32'd1);
    tick(); check("f1_ack", 32'(bus.req_ack), 32'd1);
    tick(); check("f2_ack", 32'(bus.req_ack), 32'd0);
    bus.out_ready = 1'b0;

    // Fill the FIFO back to back with no downstream accept.
    vecs[0] = '{data: 8'h03, exp_count: 3'd1};
    vecs[1] = '{data: 8'h0A, exp_count: 3'd2};
    vecs[2] = '{data: 8'h00, exp_count: 3'd3};
    vecs[3] = '{data: 8'h0C, exp_count: 3'd4};
    for (int i = 0; i < 4; i++) begin
      handshake(vecs[i].data);
      $display("txn fill data=%02h count=%0d", vecs[i].data, bus.fifo_count);
      check("fill_count", 32'(bus.fifo_count), 32'(vecs[i].exp_count));
    end

    // Fifth request stalls until one pop, then pushes a cycle later.
    bus.req_data  = 8'h07;
    bus.req_ready = 1'b1;
    exp_q.push_back(8'h07);
    tick(4);
    check("stall_ack", 32'(bus.req_ack), 32'd0);
    check("stall_state", 32'(dut.state_reg), 32'd1);
    check("stall_count", 32'(bus.fifo_count), 32'd4);
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    check("stall_pop_count", 32'(bus.fifo_count), 32'd3);
    check("stall_pop_ack", 32'(bus.req_ack), 32'd0);
    tick();
    check("stall_push_count", 32'(bus.fifo_count), 32'd4);
    check("stall_push_ack", 32'(bus.req_ack), 32'd1);
    bus.req_ready = 1'b0;
    wait_ack(1'b0, "stall_ack_fall");
    drain();

    // Held request produces exactly one push.
    bus.req_data  = 8'h09;
    bus.req_ready = 1'b1;
    exp_q.push_back(8'h09);
    tick(50);
    check("hold_count", 32'(bus.fifo_count), 32'd1);
    check("hold_ack", 32'(bus.req_ack), 32'd1);
    bus.req_ready = 1'b0;
    wait_ack(1'b0, "hold_ack_fall");

    // Simultaneous pop and push at count 2.
    handshake(8'h02);
    bus.req_data  = 8'h0B;
    bus.req_ready = 1'b1;
    exp_q.push_back(8'h0B);
    tick(2);
    check("pp_pre_count", 32'(bus.fifo_count), 32'd2);
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    check("pp_count", 32'(bus.fifo_count), 32'd2);
    check("pp_ack", 32'(bus.req_ack), 32'd1);
    bus.req_ready = 1'b0;
    wait_ack(1'b0, "pp_ack_fall");
    drain();

    // Reset while in ACK with three words buffered.
    handshake(8'h04);
    handshake(8'h06);
    bus.req_data  = 8'h08;
    bus.req_ready = 1'b1;
    exp_q.push_back(8'h08);
    wait_ack(1'b1, "pre_rst_ack");
    check("pre_rst_count", 32'(bus.fifo_count), 32'd3);
    #2 rst_n = 1'b0;
    #1;
    check("arst_ack", 32'(bus.req_ack), 32'd0);
    check("arst_valid", 32'(bus.out_valid), 32'd0);
    check("arst_count", 32'(bus.fifo_count), 32'd0);
    exp_q.delete();
    exp_q.push_back(8'h08);
    tick(2);
    rst_n = 1'b1;
    wait_ack(1'b1, "recap_ack");
    check("recap_count", 32'(bus.fifo_count), 32'd1);
    bus.req_ready = 1'b0;
    wait_ack(1'b0, "recap_ack_fall");
    drain();

    // Random transfers against random downstream backpressure.
    fork
      begin
        int v;
        for (int i = 0; i < 200; i++) begin
          v = $random % 13;
          handshake(v[7:0]);
          tick(int'($urandom_range(0, 2)));
        end
        rand_done = 1'b1;
      end
      begin
        while (!rand_done) begin
          bus.out_ready = 1'($urandom_range(0, 1));
          tick();
        end
      end
    join
    bus.out_ready = 1'b0;
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
